// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter
//   Shares one BIU port between two requesters: requester 0 is the instruction
//   memory controller, requester 1 is the data memory controller. A requester
//   keeps the grant until its whole transfer (single or burst) has been
//   acknowledged or ended by an error. While it holds req_lock_i, it also keeps
//   the grant between transfers.
//
//   Build option RV12_BIU_ARB_ROUND_ROBIN_EN:
//     defined   - on contention the requester that did not own the previous
//                 grant wins (last_owner resets to imem, so dmem wins first)
//     undefined - fixed priority, dmem over imem
//
//   Ports
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     req_*_i  [2]                  per-requester strobe and transfer fields
//     req_stb_ack_o/ack_o/err_o [2] per-requester handshakes, owner only
//     req_q_o                       shared read data, qualified by req_ack_o
//     biu_*_o                       owner's transfer fields towards the BIU
//     biu_stb_ack_i/ack_i/err_i/q_i BIU responses
//     owner_o                       current or last owner index (debug)

module riscv_biu_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PLEN        = (XLEN == 32) ? 34 : 56,
    parameter int unsigned BIUTAG_SIZE = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic [1:0]                      req_stb_i,
    output logic [1:0]                      req_stb_ack_o,
    input  logic [1:0][PLEN-1:0]            req_adr_i,
    input  logic [1:0][2:0]                 req_size_i,
    input  logic [1:0][2:0]                 req_type_i,
    input  logic [1:0]                      req_we_i,
    input  logic [1:0]                      req_lock_i,
    input  logic [1:0][2:0]                 req_prot_i,
    input  logic [1:0][XLEN-1:0]            req_d_i,
    input  logic [1:0][BIUTAG_SIZE-1:0]     req_tag_i,
    output logic [XLEN-1:0]                 req_q_o,
    output logic [1:0]                      req_ack_o,
    output logic [1:0]                      req_err_o,

    output logic                            biu_stb_o,
    input  logic                            biu_stb_ack_i,
    output logic [PLEN-1:0]                 biu_adri_o,
    output logic [2:0]                      biu_size_o,
    output logic [2:0]                      biu_type_o,
    output logic                            biu_we_o,
    output logic                            biu_lock_o,
    output logic [2:0]                      biu_prot_o,
    output logic [XLEN-1:0]                 biu_d_o,
    output logic [BIUTAG_SIZE-1:0]          biu_tagi_o,
    input  logic [XLEN-1:0]                 biu_q_i,
    input  logic                            biu_ack_i,
    input  logic                            biu_err_i,

    output logic                            owner_o
);

    typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

    localparam logic [2:0] TypeWrap4  = 3'b010;
    localparam logic [2:0] TypeIncr4  = 3'b011;
    localparam logic [2:0] TypeWrap8  = 3'b100;
    localparam logic [2:0] TypeIncr8  = 3'b101;
    localparam logic [2:0] TypeWrap16 = 3'b110;
    localparam logic [2:0] TypeIncr16 = 3'b111;

    // Number of data beats a transfer of the given type takes.
    function automatic logic [4:0] burst_beats(input logic [2:0] btype);
        case (btype)
            TypeWrap4,  TypeIncr4:  return 5'd4;
            TypeWrap8,  TypeIncr8:  return 5'd8;
            TypeWrap16, TypeIncr16: return 5'd16;
            default:                return 5'd1;   // SINGLE, INCR
        endcase
    endfunction

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [4:0] cnt_q,   cnt_d;
    logic       winner;

`ifdef RV12_BIU_ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_owner_q <= 1'b0;
        else         last_owner_q <= last_owner_d;
    end

    assign winner = (&req_stb_i) ? ~last_owner_q : req_stb_i[1];
    assign last_owner_d = (state_q == StIdle && |req_stb_i) ? winner : last_owner_q;
`else
    // dmem whenever it strobes, imem otherwise
    assign winner = req_stb_i[1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        req_stb_ack_o = 2'b00;
        req_ack_o     = 2'b00;
        req_err_o     = 2'b00;
        biu_stb_o     = 1'b0;
        biu_adri_o    = '0;
        biu_size_o    = '0;
        biu_type_o    = '0;
        biu_we_o      = 1'b0;
        biu_lock_o    = 1'b0;
        biu_prot_o    = '0;
        biu_d_o       = '0;
        biu_tagi_o    = '0;

        // The owner's fields stay on the bus while it holds the grant.
        if (state_q != StIdle) begin
            biu_adri_o = req_adr_i[owner_q];
            biu_size_o = req_size_i[owner_q];
            biu_type_o = req_type_i[owner_q];
            biu_we_o   = req_we_i[owner_q];
            biu_lock_o = req_lock_i[owner_q];
            biu_prot_o = req_prot_i[owner_q];
            biu_d_o    = req_d_i[owner_q];
            biu_tagi_o = req_tag_i[owner_q];
        end

        unique case (state_q)
            StIdle: begin
                if (|req_stb_i) begin
                    owner_d = winner;
                    cnt_d   = burst_beats(req_type_i[winner]);
                    state_d = StGrant;
                end
            end

            StGrant: begin
                biu_stb_o              = req_stb_i[owner_q];
                req_stb_ack_o[owner_q] = biu_stb_ack_i;
                req_ack_o[owner_q]     = biu_ack_i;
                req_err_o[owner_q]     = biu_err_i;
                // An error ends the burst even when it coincides with an ack.
                if (biu_err_i || (biu_ack_i && cnt_q == 5'd1)) begin
                    cnt_d   = 5'd0;
                    state_d = req_lock_i[owner_q] ? StLocked : StIdle;
                end else if (biu_ack_i && cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            StLocked: begin
                biu_lock_o = 1'b1;
                if (!req_lock_i[owner_q]) begin
                    state_d = StIdle;
                end else if (req_stb_i[owner_q]) begin
                    cnt_d   = burst_beats(req_type_i[owner_q]);
                    state_d = StGrant;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign req_q_o = biu_q_i;
    assign owner_o = owner_q;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Bench for riscv_biu_arbiter: directed scenarios followed by random traffic,
// every cycle compared with a transaction-level model (who holds the bus, how
// many beats remain, whether the grant is held by lock).

module tb_riscv_biu_arbiter;

    localparam int XLEN = 32;
    localparam int PLEN = 34;
    localparam int TW   = 1;
`ifdef RV12_BIU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]            stb, we, lock;
    logic [1:0][PLEN-1:0]  adr;
    logic [1:0][2:0]       size, typ, prot;
    logic [1:0][XLEN-1:0]  d;
    logic [1:0][TW-1:0]    tag;
    logic                  bstb_ack, back, berr;
    logic [XLEN-1:0]       bq;

    logic [1:0]            req_stb_ack, req_ack, req_err;
    logic [XLEN-1:0]       req_q;
    logic                  biu_stb, biu_we, biu_lock, owner;
    logic [PLEN-1:0]       biu_adr;
    logic [2:0]            biu_size, biu_type, biu_prot;
    logic [XLEN-1:0]       biu_d;
    logic [TW-1:0]         biu_tag;

    int checks = 0;
    int errors = 0;

    // reference model
    int         m_own;      // -1: bus free
    bit         m_held;     // grant kept by lock between transfers
    int         m_left;     // beats still expected
    bit         m_owner;    // value owner_o must show
    bit         m_rr_last;  // previous grant, for round robin
    logic [1:0] last_sack;  // predicted stb_ack of the last sampled cycle

    riscv_biu_arbiter #(.XLEN(XLEN), .PLEN(PLEN), .BIUTAG_SIZE(TW)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_stb_i     (stb),
        .req_stb_ack_o (req_stb_ack),
        .req_adr_i     (adr),
        .req_size_i    (size),
        .req_type_i    (typ),
        .req_we_i      (we),
        .req_lock_i    (lock),
        .req_prot_i    (prot),
        .req_d_i       (d),
        .req_tag_i     (tag),
        .req_q_o       (req_q),
        .req_ack_o     (req_ack),
        .req_err_o     (req_err),
        .biu_stb_o     (biu_stb),
        .biu_stb_ack_i (bstb_ack),
        .biu_adri_o    (biu_adr),
        .biu_size_o    (biu_size),
        .biu_type_o    (biu_type),
        .biu_we_o      (biu_we),
        .biu_lock_o    (biu_lock),
        .biu_prot_o    (biu_prot),
        .biu_d_o       (biu_d),
        .biu_tagi_o    (biu_tag),
        .biu_q_i       (bq),
        .biu_ack_i     (back),
        .biu_err_i     (berr),
        .owner_o       (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // SINGLE/INCR take one beat; WRAPn/INCRn take 4, 8 or 16.
    function automatic int beats(input logic [2:0] t);
        if (int'(t) < 2) return 1;
        return 4 << ((int'(t) - 2) / 2);
    endfunction

    task automatic model_reset();
        m_own = -1; m_held = 0; m_left = 0; m_owner = 0; m_rr_last = 0;
    endtask

    task automatic model_update();
        int w;
        if (m_own < 0) begin
            if (stb != 2'b00) begin
                if (stb == 2'b11) w = RR ? int'(!m_rr_last) : 1;
                else              w = int'(stb[1]);
                m_own = w; m_owner = w[0]; m_rr_last = w[0];
                m_left = beats(typ[w]); m_held = 0;
            end
        end else if (!m_held) begin
            if (berr || (back && m_left == 1)) begin
                if (lock[m_own]) m_held = 1;
                else             m_own  = -1;
            end else if (back) begin
                m_left--;
            end
        end else begin
            if (!lock[m_own]) begin
                m_own = -1; m_held = 0;
            end else if (stb[m_own]) begin
                m_held = 0; m_left = beats(typ[m_own]);
            end
        end
    endtask

    // Compare every output with the model at the falling edge.
    task automatic sample();
        logic            e_stb, e_lock, e_we;
        logic [1:0]      e_sack, e_ack, e_err;
        logic [PLEN-1:0] e_adr;
        logic [2:0]      e_size, e_type, e_prot;
        logic [XLEN-1:0] e_d;
        logic [TW-1:0]   e_tag;
        @(negedge clk);
        e_stb = 0; e_lock = 0; e_we = 0; e_sack = 0; e_ack = 0; e_err = 0;
        e_adr = '0; e_size = '0; e_type = '0; e_prot = '0; e_d = '0; e_tag = '0;
        if (m_own >= 0) begin
            e_adr = adr[m_own]; e_size = size[m_own]; e_type = typ[m_own];
            e_we = we[m_own]; e_prot = prot[m_own]; e_d = d[m_own]; e_tag = tag[m_own];
            if (m_held) begin
                e_lock = 1'b1;
            end else begin
                e_lock = lock[m_own];
                e_stb  = stb[m_own];
                e_sack[m_own] = bstb_ack;
                e_ack[m_own]  = back;
                e_err[m_own]  = berr;
            end
        end
        last_sack = e_sack;
        chk("biu_stb",   64'(biu_stb),     64'(e_stb));
        chk("biu_adr",   64'(biu_adr),     64'(e_adr));
        chk("biu_size",  64'(biu_size),    64'(e_size));
        chk("biu_type",  64'(biu_type),    64'(e_type));
        chk("biu_we",    64'(biu_we),      64'(e_we));
        chk("biu_lock",  64'(biu_lock),    64'(e_lock));
        chk("biu_prot",  64'(biu_prot),    64'(e_prot));
        chk("biu_d",     64'(biu_d),       64'(e_d));
        chk("biu_tag",   64'(biu_tag),     64'(e_tag));
        chk("req_sack",  64'(req_stb_ack), 64'(e_sack));
        chk("req_ack",   64'(req_ack),     64'(e_ack));
        chk("req_err",   64'(req_err),     64'(e_err));
        chk("req_q",     64'(req_q),       64'(bq));
        chk("owner",     64'(owner),       64'(m_owner));
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_biu_stb"},  64'(biu_stb),     64'(0));
        chk({pfx, "_biu_adr"},  64'(biu_adr),     64'(0));
        chk({pfx, "_biu_size"}, 64'(biu_size),    64'(0));
        chk({pfx, "_biu_type"}, 64'(biu_type),    64'(0));
        chk({pfx, "_biu_we"},   64'(biu_we),      64'(0));
        chk({pfx, "_biu_lock"}, 64'(biu_lock),    64'(0));
        chk({pfx, "_biu_prot"}, 64'(biu_prot),    64'(0));
        chk({pfx, "_biu_d"},    64'(biu_d),       64'(0));
        chk({pfx, "_biu_tag"},  64'(biu_tag),     64'(0));
        chk({pfx, "_sack"},     64'(req_stb_ack), 64'(0));
        chk({pfx, "_ack"},      64'(req_ack),     64'(0));
        chk({pfx, "_err"},      64'(req_err),     64'(0));
        chk({pfx, "_q"},        64'(req_q),       64'(0));
        chk({pfx, "_owner"},    64'(owner),       64'(0));
    endtask

    // Let any open transfer finish and return to a free bus.
    task automatic settle();
        stb = 0; lock = 0; bstb_ack = 1; back = 1; berr = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            advance();
            if (m_own < 0) break;
        end
        bstb_ack = 0; back = 0;
    endtask

    task automatic single_imem(input logic [PLEN-1:0] a);
        stb = 2'b01; typ[0] = 3'd0; adr[0] = a; we[0] = 0; lock = 0;
        bstb_ack = 0; back = 0; berr = 0;
        sample(); chk("single_idle_stb", 64'(biu_stb), 64'(0)); advance();
        bstb_ack = 1; back = 1; bq = 32'hDEADBEEF;
        sample();
        chk("single_adr",  64'(biu_adr),     64'(a));
        chk("single_sack", 64'(req_stb_ack), 64'(2'b01));
        chk("single_ack",  64'(req_ack),     64'(2'b01));
        chk("single_q",    64'(req_q),       64'(32'hDEADBEEF));
        advance();
        stb = 0; bstb_ack = 0; back = 0;
        sample(); chk("single_done_stb", 64'(biu_stb), 64'(0)); advance();
    endtask

    task automatic new_fields(input int r);
        adr[r]  = PLEN'({$urandom(), $urandom()});
        size[r] = 3'($urandom()); typ[r] = 3'($urandom()); prot[r] = 3'($urandom());
        we[r]   = 1'($urandom()); d[r]   = $urandom();    tag[r]  = TW'($urandom());
    endtask

    initial begin
        int n;
        stb = 0; we = 0; lock = 0; adr = '0; size = '0; typ = '0; prot = '0;
        d = '0; tag = '0; bstb_ack = 0; back = 0; berr = 0; bq = '0;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        // single read
        single_imem(34'h100);

        // contention: dmem first, dmem re-strobes and contends again
        stb = 2'b11; typ[0] = 0; typ[1] = 0; adr[0] = 34'h10; adr[1] = 34'h20;
        we = 0; bstb_ack = 0; back = 0;
        sample(); advance();
        bstb_ack = 1; back = 1;
        sample();
        chk("cont_first_owner", 64'(owner),   64'(1));
        chk("cont_first_ack",   64'(req_ack), 64'(2'b10));
        chk("cont_first_adr",   64'(biu_adr), 64'(34'h20));
        advance();
        bstb_ack = 0; back = 0;
        sample(); chk("cont_imem_wait", 64'(req_ack), 64'(0)); advance();
        sample(); chk("cont_second_owner", 64'(owner), 64'(RR ? 0 : 1)); advance();
        settle();

        // burst hold: imem WRAP8, dmem strobes at beat 2
        stb = 2'b01; typ[0] = 3'd4; adr[0] = 34'h300; typ[1] = 0; adr[1] = 34'h340;
        bstb_ack = 1; back = 0;
        sample(); advance();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            back = i[0];
            if (i == 3) stb[1] = 1;
            sample();
            if (req_ack[0]) n++;
            advance();
            if (m_own < 0) break;
        end
        chk("burst_imem_acks", 64'(n), 64'(8));
        stb[0] = 0; back = 0;
        sample(); chk("burst_idle_gap", 64'(biu_stb), 64'(0)); advance();
        sample();
        chk("burst_dmem_owner", 64'(owner),   64'(1));
        chk("burst_dmem_stb",   64'(biu_stb), 64'(1));
        advance();
        settle();

        // error mid-burst: imem INCR4, error on beat 2
        stb = 2'b01; typ[0] = 3'd3; adr[0] = 34'h400; bstb_ack = 1; back = 0; berr = 0;
        sample(); advance();
        back = 1; stb[1] = 1; typ[1] = 0; adr[1] = 34'h500;
        sample(); chk("err_beat1_ack", 64'(req_ack), 64'(2'b01)); advance();
        back = 0; berr = 1;
        sample(); chk("err_flag", 64'(req_err), 64'(2'b01)); advance();
        berr = 0; back = 1;
        sample();
        chk("err_idle_err", 64'(req_err), 64'(0));
        chk("err_idle_ack", 64'(req_ack), 64'(0));
        advance();
        sample();
        chk("err_next_owner",   64'(owner),      64'(1));
        chk("err_imem_no_ack",  64'(req_ack[0]), 64'(0));
        advance();
        settle();

        // locked read then write by dmem, imem blocked
        stb = 2'b10; lock = 2'b10; typ[1] = 0; we[1] = 0; adr[1] = 34'h600;
        typ[0] = 0; adr[0] = 34'h610; bstb_ack = 1; back = 0;
        sample(); advance();
        stb[0] = 1; back = 1;
        sample();
        chk("lock_read_ack", 64'(req_ack),  64'(2'b10));
        chk("lock_grant",    64'(biu_lock), 64'(1));
        advance();
        stb[1] = 0; back = 0;
        sample();
        chk("lock_held",         64'(biu_lock),    64'(1));
        chk("lock_imem_blocked", 64'(req_stb_ack), 64'(0));
        chk("lock_owner",        64'(owner),       64'(1));
        advance();
        stb[1] = 1; we[1] = 1; d[1] = 32'hCAFEF00D;
        sample(); chk("lock_held2", 64'(biu_lock), 64'(1)); advance();
        back = 1;
        sample();
        chk("lock_write_we",   64'(biu_we),   64'(1));
        chk("lock_write_ack",  64'(req_ack),  64'(2'b10));
        chk("lock_write_lock", 64'(biu_lock), 64'(1));
        advance();
        stb[1] = 0; back = 0; lock[1] = 0;
        sample(); advance();
        sample(); chk("lock_drop_idle", 64'(biu_stb), 64'(0)); advance();
        sample(); chk("lock_imem_owner", 64'(owner), 64'(0)); advance();
        settle();

        // reset during beat 3 of an INCR8
        stb = 2'b01; typ[0] = 3'd5; adr[0] = 34'h700; we = 0; bstb_ack = 1; back = 1;
        sample(); advance();
        sample(); advance();
        sample(); advance();
        sample();
        #1 rst_n = 0; bq = '0;
        #1 chk_zero("midrst");
        model_reset();
        stb = 0; back = 0; bstb_ack = 0;
        @(posedge clk);
        #1 rst_n = 1;
        single_imem(34'h104);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bstb_ack = 1'($urandom());
            back     = 1'($urandom());
            berr     = ($urandom_range(15) == 0);
            bq       = $urandom();
            sample();
            advance();
            for (int r = 0; r < 2; r++) begin
                if (stb[r]) begin
                    if (last_sack[r]) begin
                        if ($urandom_range(1) == 0) stb[r] = 0;
                        else                        new_fields(r);
                    end
                end else if ($urandom_range(3) == 0) begin
                    stb[r] = 1;
                    new_fields(r);
                end
                if (!stb[r] && $urandom_range(15) == 0) lock[r] = ~lock[r];
            end
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
